// File: rtl/dma_line_reader.sv
// dma_line_reader: read-DMA front end. Turns a start request into a series of
// BEATS-beat, 32-bit read bursts and packs each burst into one line that is
// presented on dma_data with a single-cycle dma_done pulse.
module dma_line_reader #(
    parameter int BEATS = 8,
    parameter int LEN_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dma_start,
    input  logic [31:0]         addr,
    input  logic [LEN_W-1:0]    line_cnt,
    output logic                busy,
    output logic [32*BEATS-1:0] dma_data,
    output logic                dma_done,
    output logic                xfer_done,
    output logic                err,
    output logic                ar_valid,
    input  logic                ar_ready,
    output logic [31:0]         ar_addr,
    output logic [7:0]          ar_len,
    input  logic                r_valid,
    input  logic [31:0]         r_data,
    input  logic                r_last,
    output logic                r_ready
);
    localparam int                LINE_W     = 32 * BEATS;
    localparam int                BCNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0]       LINE_BYTES = 32'(4 * BEATS);
    localparam logic [31:0]       ALIGN_MASK = LINE_BYTES - 32'd1;
    localparam logic [BCNT_W-1:0] LAST_BEAT  = BCNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_r,     state_s;
    logic [31:0]         cur_addr_r,  cur_addr_s;
    logic [LEN_W-1:0]    remaining_r, remaining_s;
    logic [BCNT_W-1:0]   beat_cnt_r,  beat_cnt_s;
    logic [LINE_W-1:0]   line_r,      line_s;
    logic                empty_r,     empty_s;     // current DONE carries no line
    logic                err_r,       err_s;
    logic [31:0]         ar_addr_r,   ar_addr_s;
    logic [LINE_W-1:0]   dma_data_r,  dma_data_s;
    logic                dma_done_r,  dma_done_s;
    logic                xfer_done_r, xfer_done_s;
    logic                busy_r;
    logic                ar_valid_r;
    logic                r_ready_r;
    logic                last_beat_s;

    // Place one 32-bit beat into its slot of the line; beat 0 lands in the LSBs.
    function automatic logic [LINE_W-1:0] insert_beat(input logic [LINE_W-1:0] line,
                                                      input logic [BCNT_W-1:0] idx,
                                                      input logic [31:0]       beat);
        logic [LINE_W-1:0] res;
        res = line;
        res[32 * int'(idx) +: 32] = beat;
        return res;
    endfunction

    assign last_beat_s = (beat_cnt_r == LAST_BEAT);

    // Next-state and next-register computation for the line-fetch sequence
    always_comb begin
        state_s     = state_r;
        cur_addr_s  = cur_addr_r;
        remaining_s = remaining_r;
        beat_cnt_s  = beat_cnt_r;
        line_s      = line_r;
        empty_s     = empty_r;
        err_s       = err_r;
        ar_addr_s   = ar_addr_r;
        dma_data_s  = dma_data_r;
        dma_done_s  = 1'b0;
        xfer_done_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (dma_start) begin
                    cur_addr_s  = addr;
                    remaining_s = line_cnt;
                    err_s       = 1'b0;
                    if ((addr & ALIGN_MASK) != 32'd0) begin
                        // misaligned: flag it and finish without touching the bus
                        err_s       = 1'b1;
                        empty_s     = 1'b1;
                        xfer_done_s = 1'b1;
                        state_s     = S_DONE;
                    end else if (line_cnt == {LEN_W{1'b0}}) begin
                        empty_s     = 1'b1;
                        xfer_done_s = 1'b1;
                        state_s     = S_DONE;
                    end else begin
                        empty_s   = 1'b0;
                        ar_addr_s = addr;
                        state_s   = S_ADDR;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (ar_ready) begin
                    beat_cnt_s = {BCNT_W{1'b0}};
                    state_s    = S_DATA;
                end else begin
                    state_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (r_valid && r_ready_r) begin
                    line_s     = insert_beat(line_r, beat_cnt_r, r_data);
                    beat_cnt_s = beat_cnt_r + BCNT_W'(1);
                    // r_last must coincide exactly with the final beat
                    if (r_last != last_beat_s) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    if (last_beat_s) begin
                        dma_data_s  = line_s;
                        dma_done_s  = 1'b1;
                        xfer_done_s = (remaining_r == LEN_W'(1));
                        state_s     = S_DONE;
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
            S_DONE: begin
                if (empty_r) begin
                    state_s = S_IDLE;
                end else begin
                    cur_addr_s  = cur_addr_r + LINE_BYTES;
                    remaining_s = remaining_r - LEN_W'(1);
                    if (remaining_s == {LEN_W{1'b0}}) begin
                        state_s = S_IDLE;
                    end else begin
                        ar_addr_s = cur_addr_s;
                        state_s   = S_ADDR;
                    end
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset returns everything to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cur_addr_r  <= 32'd0;
            remaining_r <= {LEN_W{1'b0}};
            beat_cnt_r  <= {BCNT_W{1'b0}};
            line_r      <= {LINE_W{1'b0}};
            empty_r     <= 1'b0;
            err_r       <= 1'b0;
            ar_addr_r   <= 32'd0;
            dma_data_r  <= {LINE_W{1'b0}};
            dma_done_r  <= 1'b0;
            xfer_done_r <= 1'b0;
            busy_r      <= 1'b0;
            ar_valid_r  <= 1'b0;
            r_ready_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cur_addr_r  <= cur_addr_s;
            remaining_r <= remaining_s;
            beat_cnt_r  <= beat_cnt_s;
            line_r      <= line_s;
            empty_r     <= empty_s;
            err_r       <= err_s;
            ar_addr_r   <= ar_addr_s;
            dma_data_r  <= dma_data_s;
            dma_done_r  <= dma_done_s;
            xfer_done_r <= xfer_done_s;
            busy_r      <= (state_s != S_IDLE);
            ar_valid_r  <= (state_s == S_ADDR);
            r_ready_r   <= (state_s == S_DATA);
        end
    end

    assign busy      = busy_r;
    assign dma_data  = dma_data_r;
    assign dma_done  = dma_done_r;
    assign xfer_done = xfer_done_r;
    assign err       = err_r;
    assign ar_valid  = ar_valid_r;
    assign ar_addr   = ar_addr_r;
    assign ar_len    = 8'(BEATS - 1);
    assign r_ready   = r_ready_r;

endmodule

// File: tb/tb_dma_line_reader.sv
// tb_dma_line_reader: table-driven bench with a memory model and a
// scoreboard of expected burst addresses and packed lines.
module tb_dma_line_reader;
    logic         clk;
    logic         rst;
    logic         dma_start;
    logic [31:0]  addr;
    logic [15:0]  line_cnt;
    logic         busy;
    logic [255:0] dma_data;
    logic         dma_done;
    logic         xfer_done;
    logic         err;
    logic         ar_valid;
    logic         ar_ready;
    logic [31:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         r_valid;
    logic [31:0]  r_data;
    logic         r_last;
    logic         r_ready;

    dma_line_reader #(.BEATS(8), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .dma_start(dma_start), .addr(addr), .line_cnt(line_cnt),
        .busy(busy), .dma_data(dma_data), .dma_done(dma_done), .xfer_done(xfer_done),
        .err(err), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .ar_len(ar_len), .r_valid(r_valid), .r_data(r_data), .r_last(r_last),
        .r_ready(r_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] cnt;
        bit          ar_st;      // random ar_ready stalls
        bit          r_st;       // random r_valid gaps
        int          last_pos;   // beat index carrying r_last
        bit          plain;      // 0x11..0x88 data pattern
        int          inj_cyc;    // cycle of an extra start while busy (0 = none)
        bit          exp_err;
        int          exp_lines;
        int          exp_xfer;   // expected xfer_done cycle, -1 = not fixed
    } vec_t;

    localparam logic [255:0] LIT_LINE =
        256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011;

    vec_t vecs [8];
    int n_cmp, n_bad;
    int cyc, n_done, n_xfer, n_bursts, n_beats, n_arv, xfer_cyc, last_done_cyc;
    logic [255:0] last_line;
    logic [31:0]  exp_addr_q [$];
    logic [255:0] exp_line_q [$];
    bit           bursting, ar_wait, ar_stall, r_stall, plain;
    logic [31:0]  burst_addr, ar_wait_addr;
    int           beat_i, last_pos;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] beat_word(input logic [31:0] a, input int k, input bit pl);
        logic [31:0] kk;
        kk = 32'(k);
        if (pl) return 32'h11 * (kk + 32'd1);
        else    return {a[23:0], 8'h00} ^ (kk * 32'h01010101) ^ 32'h5A000000;
    endfunction

    function automatic logic [255:0] exp_line(input logic [31:0] a, input bit pl);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = beat_word(a, k, pl);
        return l;
    endfunction

    // Observe outputs of the current cycle, then drive memory inputs for the next edge.
    task automatic monitor();
        logic [255:0] e;
        logic [31:0]  ea;
        check("ar_rready_excl", {255'd0, ar_valid & r_ready}, 256'd0);
        if (ar_wait) begin
            check("ar_hold_valid", {255'd0, ar_valid}, 256'd1);
            check("ar_hold_addr", {224'd0, ar_addr}, {224'd0, ar_wait_addr});
        end
        if (dma_done) begin
            n_done++;
            last_done_cyc = cyc;
            last_line = dma_data;
            if (exp_line_q.size() == 0) check("dma_done_unexpected", 256'd1, 256'd0);
            else begin
                e = exp_line_q.pop_front();
                check("dma_data", dma_data, e);
            end
        end
        if (xfer_done) begin
            n_xfer++;
            xfer_cyc = cyc;
        end
        if (ar_valid) n_arv++;
        ar_ready = ar_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        ar_wait = ar_valid && !ar_ready;
        ar_wait_addr = ar_addr;
        if (ar_valid && ar_ready) begin
            n_bursts++;
            check("ar_len", {248'd0, ar_len}, 256'd7);
            if (exp_addr_q.size() == 0) check("ar_unexpected", 256'd1, 256'd0);
            else begin
                ea = exp_addr_q.pop_front();
                check("ar_addr", {224'd0, ar_addr}, {224'd0, ea});
            end
            burst_addr = ar_addr;
            beat_i = 0;
            bursting = 1'b1;
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_data  = 32'd0;
        if (bursting && r_ready && beat_i < 8) begin
            r_valid = r_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            r_data  = beat_word(burst_addr, beat_i, plain);
            r_last  = (beat_i == last_pos);
            if (r_valid) begin
                beat_i++;
                n_beats++;
                if (beat_i == 8) bursting = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        dma_start = 1'b0;
        monitor();
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.exp_lines; i++) begin
            exp_addr_q.push_back(v.addr + 32'(32 * i));
            exp_line_q.push_back(exp_line(v.addr + 32'(32 * i), v.plain));
        end
        n_done = 0; n_xfer = 0; n_bursts = 0; n_beats = 0; n_arv = 0;
        xfer_cyc = -1; last_done_cyc = -1;
        ar_stall = v.ar_st; r_stall = v.r_st; last_pos = v.last_pos; plain = v.plain;
        addr = v.addr; line_cnt = v.cnt; dma_start = 1'b1;
        cyc = 0;
        tick();
        check("busy_c1", {255'd0, busy}, 256'd1);
        check("err_c1", {255'd0, err}, {255'd0, v.addr[4:0] != 5'd0});
        check("ar_valid_c1", {255'd0, ar_valid}, {255'd0, v.exp_lines > 0});
        while (n_xfer == 0 && cyc < 2000) begin
            if (v.inj_cyc > 0 && cyc == v.inj_cyc) begin
                dma_start = 1'b1; addr = 32'h0000_7000; line_cnt = 16'd5;
            end
            tick();
        end
        check("xfer_seen", {255'd0, n_xfer != 0}, 256'd1);
        if (v.exp_xfer >= 0) check("xfer_cycle", 256'(xfer_cyc), 256'(v.exp_xfer));
        if (v.exp_lines > 0) check("done_with_xfer", 256'(last_done_cyc), 256'(xfer_cyc));
        tick();
        check("busy_after", {255'd0, busy}, 256'd0);
        tick();
        check("err_final", {255'd0, err}, {255'd0, v.exp_err});
        check("n_xfer", 256'(n_xfer), 256'd1);
        check("n_done", 256'(n_done), 256'(v.exp_lines));
        check("n_bursts", 256'(n_bursts), 256'(v.exp_lines));
        check("n_beats", 256'(n_beats), 256'(8 * v.exp_lines));
        check("no_ar_when_empty", {255'd0, n_arv == 0}, {255'd0, v.exp_lines == 0});
        check("lines_left", 256'(exp_line_q.size()), 256'd0);
        if (v.plain) check("line_literal", last_line, LIT_LINE);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1; dma_start = 1'b0; addr = 32'd0; line_cnt = 16'd0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = 32'd0; r_last = 1'b0;
        bursting = 1'b0; ar_wait = 1'b0; ar_stall = 1'b0; r_stall = 1'b0;
        plain = 1'b0; last_pos = 7; beat_i = 0; burst_addr = 32'd0; ar_wait_addr = 32'd0;
        last_line = 256'd0;

        //          addr           cnt     ars   rs    lp pl   inj ee    lines xfer
        vecs[0] = '{32'h0000_1000, 16'd1, 1'b0, 1'b0, 7, 1'b1, 0, 1'b0, 1, 10};
        vecs[1] = '{32'h0000_2000, 16'd4, 1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 4, -1};
        vecs[2] = '{32'h0000_3000, 16'd0, 1'b0, 1'b0, 7, 1'b0, 0, 1'b0, 0, 1};
        vecs[3] = '{32'h0000_1004, 16'd1, 1'b0, 1'b0, 7, 1'b0, 0, 1'b1, 0, 1};
        vecs[4] = '{32'h0000_4000, 16'd1, 1'b0, 1'b0, 3, 1'b0, 0, 1'b1, 1, 10};
        vecs[5] = '{32'hFFFF_FFE0, 16'd2, 1'b0, 1'b0, 7, 1'b0, 0, 1'b0, 2, 20};
        vecs[6] = '{32'h0000_6000, 16'd3, 1'b0, 1'b0, 7, 1'b0, 15, 1'b0, 3, 30};
        vecs[7] = '{32'h0000_5000, 16'd2, 1'b1, 1'b0, 7, 1'b0, 0, 1'b0, 2, -1};

        @(negedge clk);
        tick(); tick(); tick();
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_flags", {252'd0, dma_done, xfer_done, err, ar_valid}, 256'd0);
        check("rst_r_ready", {255'd0, r_ready}, 256'd0);
        check("rst_ar_addr", {224'd0, ar_addr}, 256'd0);
        check("rst_dma_data", dma_data, 256'd0);
        check("rst_ar_len", {248'd0, ar_len}, 256'd7);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while collecting beats of the first line
        exp_addr_q.push_back(32'h0000_8000);
        ar_stall = 1'b0; r_stall = 1'b0; last_pos = 7; plain = 1'b0;
        addr = 32'h0000_8000; line_cnt = 16'd2; dma_start = 1'b1; cyc = 0;
        while (cyc < 5) tick();
        check("pre_rst_r_ready", {255'd0, r_ready}, 256'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_flags", {250'd0, busy, dma_done, xfer_done, err, ar_valid, r_ready}, 256'd0);
        check("mid_rst_ar_addr", {224'd0, ar_addr}, 256'd0);
        check("mid_rst_dma_data", dma_data, 256'd0);
        bursting = 1'b0; ar_wait = 1'b0;
        exp_addr_q.delete();
        exp_line_q.delete();
        for (int i = 0; i < 4; i++) begin
            r_valid = 1'b1; r_data = 32'hDEAD_BEEF; r_last = (i == 3);
            tick();
            check("post_rst_r_ready", {255'd0, r_ready}, 256'd0);
            check("post_rst_busy", {255'd0, busy}, 256'd0);
        end

        run_vec('{32'h0000_9000, 16'd1, 1'b0, 1'b0, 7, 1'b0, 0, 1'b0, 1, 10});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
